// File: rtl/fwft_prefetch_adapter.sv
// Turns a standard-read FIFO (data RD_LATENCY cycles after rd_en) into a first-word-fall-through
// valid/ready stream via a DEPTH-entry prefetch buffer. Optional flush port: FWFT_PREFETCH_FLUSH_EN.
module fwft_prefetch_adapter #(
  parameter int WIDTH      = 512,
  parameter int DEPTH      = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty_i,
  output logic                       fifo_rd_en_o,
  input  logic [WIDTH-1:0]           fifo_dout_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o
`ifdef FWFT_PREFETCH_FLUSH_EN
  ,
  input  logic                       flush_i
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = CW + 2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0]         count;
  logic [RD_LATENCY-1:0] inflight_sr;
  logic [AW-1:0]         inflight, credit;
  logic                  pop, capture, flush;
  logic [WIDTH-1:0]      dout_r, dout_next;

`ifdef FWFT_PREFETCH_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign valid_o    = (count != '0);
  assign dout_o     = dout_r;
  assign level_o    = count;
  assign pop        = valid_o & ready_i & ~flush;
  assign capture    = inflight_sr[RD_LATENCY-1];
  assign rd_ptr_inc = rd_ptr + PW'(1);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + AW'(inflight_sr[i]);
  end

  // Slots already promised to in-flight reads count as occupied; a slot freed by
  // this cycle's pop can be re-issued immediately.
  assign credit       = AW'(count) + inflight - AW'(pop);
  assign fifo_rd_en_o = ~rst & ~fifo_empty_i & ~flush & (credit < AW'(DEPTH));

  // dout is its own register so it can hold the last word while the buffer is empty.
  always_comb begin
    dout_next = dout_r;
    if (pop) begin
      if (count == CW'(1)) begin
        if (capture) dout_next = fifo_dout_i;
      end else begin
        dout_next = mem[rd_ptr_inc];
      end
    end else if (count == '0 && capture) begin
      dout_next = fifo_dout_i;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= fifo_dout_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight_sr <= '0;
      dout_r      <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight_sr <= '0;
    end else begin
      inflight_sr <= (inflight_sr << 1) | RD_LATENCY'(fifo_rd_en_o);
      if (capture) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr_inc;
      count  <= count + CW'(capture) - CW'(pop);
      dout_r <= dout_next;
    end
  end

  // A capture into a full buffer without a simultaneous pop means the credit logic broke.
  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(capture && !pop && count == CW'(DEPTH)));
  end

endmodule
